// File: rtl/word_serializer_tx_pkg.sv
// Shared definitions for the word serializer: FSM state encoding and
// elaboration-time sizing helpers.
package word_serializer_tx_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SEND       = 3'd1,
        WAIT_DONE  = 3'd2,
        FINISH     = 3'd3,
        CHECK_SEND = 3'd4,
        CHECK_WAIT = 3'd5
    } state_t;

    // Ceiling log2, never below 1 so a one-entry index still has a bit.
    function automatic int clog2(input int value);
        int result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) result++;
        return (result < 1) ? 1 : result;
    endfunction

    function automatic int nbytes(input int word_width, input int byte_width);
        return word_width / byte_width;
    endfunction

endpackage

// File: rtl/word_serializer_tx_watchdog.sv
// Reusable wait-timeout counter: clear restarts it, enable advances it, and
// timeout flags the TIMEOUT_CYCLES-th cycle since the clear cycle (0 disables).
module tx_watchdog
    import word_serializer_tx_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int CNT_W = clog2(TIMEOUT_CYCLES + 1);
    localparam int LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    logic [CNT_W-1:0] count;

    // The clear cycle itself is the first counted cycle, hence the load of 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= CNT_W'(1);
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = (TIMEOUT_CYCLES > 0) && enable && (count >= CNT_W'(LIMIT));

endmodule

// File: rtl/word_serializer_tx.sv
// Splits one word into UART bytes, MSB first, handshaking each byte with tx.
// Define WORD_SERIALIZER_CHECKSUM_EN to append an XOR checksum byte.
module word_serializer_tx
    import word_serializer_tx_pkg::*;
#(
    parameter int LONGITUD_INSTRUCCION = 32,
    parameter int OUTPUT_WORD_LENGTH   = 8,
    parameter int TIMEOUT_CYCLES       = 1048576
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic                            i_soft_reset,
    input  logic                            i_start,
    input  logic [LONGITUD_INSTRUCCION-1:0] i_word,
    input  logic                            i_tx_done,
    output logic                            o_tx_start,
    output logic [OUTPUT_WORD_LENGTH-1:0]   o_data_tx,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_error
);

    localparam int W      = LONGITUD_INSTRUCCION;
    localparam int B      = OUTPUT_WORD_LENGTH;
    localparam int NBYTES = nbytes(W, B);
    localparam int IDX_W  = clog2(NBYTES);

    state_t           state;
    logic [W-1:0]     word_q;
    logic [W-1:0]     word_shift;
    logic [IDX_W-1:0] idx;
    logic             last_byte;
    logic             wd_clear;
    logic             wd_enable;
    logic             wd_timeout;

    // The pending bytes always sit at the top of word_q.
    assign word_shift = word_q << B;
    assign last_byte  = (idx == IDX_W'(NBYTES - 1));

`ifdef WORD_SERIALIZER_CHECKSUM_EN
    logic [B-1:0] word_xor;
    logic [B-1:0] checksum_q;

    always_comb begin
        word_xor = '0;
        for (int k = 0; k < NBYTES; k++) word_xor ^= i_word[k*B +: B];
    end

    assign wd_clear  = !i_soft_reset || (state == SEND) || (state == CHECK_SEND);
    assign wd_enable = (state == WAIT_DONE) || (state == CHECK_WAIT);
`else
    assign wd_clear  = !i_soft_reset || (state == SEND);
    assign wd_enable = (state == WAIT_DONE);
`endif

    tx_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (i_clock),
        .rst_n  (i_reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .timeout(wd_timeout)
    );

    // NOTE: the word register is reset along with the FSM so a soft or hard
    // reset leaves no stale byte that could leak onto o_data_tx.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state      <= IDLE;
            word_q     <= '0;
            idx        <= '0;
            o_tx_start <= 1'b0;
            o_data_tx  <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_error    <= 1'b0;
`ifdef WORD_SERIALIZER_CHECKSUM_EN
            checksum_q <= '0;
`endif
        end else if (!i_soft_reset) begin
            state      <= IDLE;
            word_q     <= '0;
            idx        <= '0;
            o_tx_start <= 1'b0;
            o_data_tx  <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_error    <= 1'b0;
`ifdef WORD_SERIALIZER_CHECKSUM_EN
            checksum_q <= '0;
`endif
        end else begin
            o_tx_start <= 1'b0;
            o_done     <= 1'b0;
            o_error    <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        word_q     <= i_word;
                        idx        <= '0;
                        o_data_tx  <= i_word[W-1 -: B];
                        o_tx_start <= 1'b1;
                        o_busy     <= 1'b1;
                        state      <= SEND;
`ifdef WORD_SERIALIZER_CHECKSUM_EN
                        checksum_q <= word_xor;
`endif
                    end
                end
                SEND: state <= WAIT_DONE;
                WAIT_DONE: begin
                    // A completed byte wins over a timeout landing in the same cycle.
                    if (i_tx_done) begin
                        if (!last_byte) begin
                            idx        <= idx + 1'b1;
                            word_q     <= word_shift;
                            o_data_tx  <= word_shift[W-1 -: B];
                            o_tx_start <= 1'b1;
                            state      <= SEND;
                        end else begin
`ifdef WORD_SERIALIZER_CHECKSUM_EN
                            o_data_tx  <= checksum_q;
                            o_tx_start <= 1'b1;
                            state      <= CHECK_SEND;
`else
                            o_done     <= 1'b1;
                            state      <= FINISH;
`endif
                        end
                    end else if (wd_timeout) begin
                        o_error <= 1'b1;
                        o_busy  <= 1'b0;
                        state   <= IDLE;
                    end
                end
`ifdef WORD_SERIALIZER_CHECKSUM_EN
                CHECK_SEND: state <= CHECK_WAIT;
                CHECK_WAIT: begin
                    if (i_tx_done) begin
                        o_done <= 1'b1;
                        state  <= FINISH;
                    end else if (wd_timeout) begin
                        o_error <= 1'b1;
                        o_busy  <= 1'b0;
                        state   <= IDLE;
                    end
                end
`endif
                FINISH: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_word_serializer_tx.sv
// Directed bench for word_serializer_tx with a byte scoreboard; a second
// instance with a short watchdog exercises the timeout path.
`timescale 1ns/1ps
module tb_word_serializer_tx;

`ifdef WORD_SERIALIZER_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        soft_rst_n = 1'b1;
    logic        start = 1'b0;
    logic        tx_done = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] word = '0;

    logic       m_start, m_tx_done, m_tx_start, m_busy, m_done, m_error;
    logic       w_start, w_tx_done, w_tx_start, w_busy, w_done, w_error;
    logic [7:0] m_data, w_data;
    logic       obs_tx_start, obs_busy, obs_done, obs_error;
    logic [7:0] obs_data;

    int         n_compared = 0;
    int         n_mismatched = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    assign m_start   = start & ~sel;
    assign w_start   = start & sel;
    assign m_tx_done = tx_done & ~sel;
    assign w_tx_done = tx_done & sel;

    assign obs_tx_start = sel ? w_tx_start : m_tx_start;
    assign obs_data     = sel ? w_data     : m_data;
    assign obs_busy     = sel ? w_busy     : m_busy;
    assign obs_done     = sel ? w_done     : m_done;
    assign obs_error    = sel ? w_error    : m_error;

    word_serializer_tx #(.TIMEOUT_CYCLES(1048576)) dut (
        .i_clock(clk), .i_reset(rst_n), .i_soft_reset(soft_rst_n),
        .i_start(m_start), .i_word(word), .i_tx_done(m_tx_done),
        .o_tx_start(m_tx_start), .o_data_tx(m_data), .o_busy(m_busy),
        .o_done(m_done), .o_error(m_error)
    );

    word_serializer_tx #(.TIMEOUT_CYCLES(16)) dut_wd (
        .i_clock(clk), .i_reset(rst_n), .i_soft_reset(soft_rst_n),
        .i_start(w_start), .i_word(word), .i_tx_done(w_tx_done),
        .o_tx_start(w_tx_start), .o_data_tx(w_data), .o_busy(w_busy),
        .o_done(w_done), .o_error(w_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        logic [7:0] x;
        x = '0;
        for (int i = 3; i >= 0; i--) begin
            exp_q.push_back(w[i*8 +: 8]);
            x ^= w[i*8 +: 8];
        end
`ifdef WORD_SERIALIZER_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tx_start"}, 32'(obs_tx_start), 32'd0);
        check({tag, "_data"},     32'(obs_data),     32'd0);
        check({tag, "_busy"},     32'(obs_busy),     32'd0);
        check({tag, "_done"},     32'(obs_done),     32'd0);
        check({tag, "_error"},    32'(obs_error),    32'd0);
    endtask

    // Cycle-by-cycle driver/monitor: answers each byte after resp_delay cycles
    // (0 = never), optionally injects a start or a spurious tx_done.
    task automatic serve(input int resp_delay, input int max_cycles, input int inject_at,
                         input int stop_after, input bit spur_send,
                         output int ns, output int nd, output int tf, output int td,
                         output int te, output int tl, output int t2);
        int due;
        due = -1; ns = 0; nd = 0; tf = -1; td = -1; te = -1; tl = -1; t2 = -1;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            start   = 1'b0;
            tx_done = 1'b0;
            if (obs_tx_start) begin
                ns++;
                if (ns == 1) begin
                    tf = c;
                    check("busy_in_flight", 32'(obs_busy), 32'd1);
                    if (spur_send) tx_done = 1'b1;
                end
                if (ns == 2) t2 = c;
                if (exp_q.size() == 0) check("extra_byte", 32'(obs_data), 32'hFFFF_FFFF);
                else check("byte", 32'(obs_data), 32'(exp_q.pop_front()));
                if (resp_delay > 0) due = c + resp_delay;
                if (inject_at > 0 && ns == inject_at) begin
                    word  = 32'h1234_5678;
                    start = 1'b1;
                end
            end
            if (obs_done) begin nd++; td = c; end
            if (obs_error) te = c;
            if (c == due) begin tx_done = 1'b1; tl = c; end
            if (obs_done || obs_error || (stop_after > 0 && ns == stop_after)) break;
        end
    endtask

    task automatic idle_window(input int n, output int starts, output int dones, output int busy_hi);
        starts = 0; dones = 0; busy_hi = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            start   = 1'b0;
            tx_done = 1'b0;
            if (obs_tx_start) starts++;
            if (obs_done) dones++;
            if (obs_busy) busy_hi++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: observed=expired expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int ns, nd, tf, td, te, tl, t2;
        int i_starts, i_dones, i_busy;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Normal word, bytes answered 20 cycles after each start
        push_word(32'hDEAD_BEEF);
        word = 32'hDEAD_BEEF; start = 1'b1;
        serve(20, 400, 0, 0, 1'b0, ns, nd, tf, td, te, tl, t2);
        check("normal_starts", 32'(ns), 32'(NB));
        check("normal_done_cnt", 32'(nd), 32'd1);
        check("normal_done_latency", 32'(td - tl), 32'd1);
        check("normal_queue_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("normal_busy_after", 32'(obs_busy), 32'd0);

        // Start while busy is ignored, not queued
        push_word(32'hDEAD_BEEF);
        word = 32'hDEAD_BEEF; start = 1'b1;
        serve(20, 400, 2, 0, 1'b0, ns, nd, tf, td, te, tl, t2);
        check("busy_starts", 32'(ns), 32'(NB));
        check("busy_done_cnt", 32'(nd), 32'd1);
        idle_window(40, i_starts, i_dones, i_busy);
        check("busy_no_queued_start", 32'(i_starts), 32'd0);
        check("busy_no_extra_done", 32'(i_dones), 32'd0);

        // Watchdog timeout on the 16-cycle instance
        sel = 1'b1;
        @(negedge clk);
        push_word(32'hDEAD_BEEF);
        word = 32'hDEAD_BEEF; start = 1'b1;
        serve(0, 100, 0, 0, 1'b0, ns, nd, tf, td, te, tl, t2);
        check("timeout_starts", 32'(ns), 32'd1);
        check("timeout_no_done", 32'(nd), 32'd0);
        check("timeout_latency", 32'(te - tf), 32'd16);
        exp_q.delete();
        @(negedge clk);
        check("timeout_busy_after", 32'(obs_busy), 32'd0);
        check("timeout_error_pulse", 32'(obs_error), 32'd0);
        push_word(32'h0000_0001);
        word = 32'h0000_0001; start = 1'b1;
        serve(5, 200, 0, 0, 1'b0, ns, nd, tf, td, te, tl, t2);
        check("after_timeout_starts", 32'(ns), 32'(NB));
        check("after_timeout_done", 32'(nd), 32'd1);
        check("after_timeout_no_error", 32'(te), 32'hFFFF_FFFF);
        sel = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of the second byte
        push_word(32'hDEAD_BEEF);
        word = 32'hDEAD_BEEF; start = 1'b1;
        serve(20, 400, 0, 2, 1'b0, ns, nd, tf, td, te, tl, t2);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tx_done = 1'b1;
        idle_window(10, i_starts, i_dones, i_busy);
        check("late_done_after_reset_starts", 32'(i_starts), 32'd0);
        check("late_done_after_reset_busy", 32'(i_busy), 32'd0);

        // Synchronous soft reset: takes effect at the next edge only
        push_word(32'hDEAD_BEEF);
        word = 32'hDEAD_BEEF; start = 1'b1;
        serve(20, 400, 0, 2, 1'b0, ns, nd, tf, td, te, tl, t2);
        repeat (3) @(negedge clk);
        soft_rst_n = 1'b0;
        #1 check("soft_reset_not_async", 32'(obs_busy), 32'd1);
        @(negedge clk);
        check_outputs_zero("soft_reset");
        soft_rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        tx_done = 1'b1;
        idle_window(10, i_starts, i_dones, i_busy);
        check("late_done_after_soft_starts", 32'(i_starts), 32'd0);
        check("late_done_after_soft_busy", 32'(i_busy), 32'd0);

        // Spurious tx_done in IDLE, then in the SEND cycle
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("spur_idle_busy", 32'(obs_busy), 32'd0);
        check("spur_idle_tx_start", 32'(obs_tx_start), 32'd0);
        push_word(32'hDEAD_BEEF);
        word = 32'hDEAD_BEEF; start = 1'b1;
        serve(20, 400, 0, 0, 1'b1, ns, nd, tf, td, te, tl, t2);
        check("spur_send_starts", 32'(ns), 32'(NB));
        check("spur_send_second_byte_gap", 32'(t2 - tf), 32'd21);
        check("spur_send_done", 32'(nd), 32'd1);
        check("spur_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
